// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame controller and its "110" bit detector.
package seq_pkg;

    localparam int unsigned BitsPerByte = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } frame_state_e;

    typedef enum logic [1:0] {
        DetIdle = 2'd0,
        DetS1   = 2'd1,
        DetS11  = 2'd2
    } det_state_e;

endpackage

// File: rtl/seq_bit_det.sv
// Mealy "110" recognizer; patterns do not overlap and state advances only when i_bit_en is high.
module seq_bit_det
    import seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_bit_en,
    input  logic i_bit_in,
    output logic o_hit
);

    det_state_e r_state;
    det_state_e w_state_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DetIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_hit       = 1'b0;
        if (i_clr) begin
            w_state_nxt = DetIdle;
        end else if (i_bit_en) begin
            case (r_state)
                DetIdle: w_state_nxt = i_bit_in ? DetS1 : DetIdle;
                DetS1:   w_state_nxt = i_bit_in ? DetS11 : DetIdle;
                DetS11: begin
                    if (i_bit_in) begin
                        w_state_nxt = DetS11;
                    end else begin
                        o_hit       = 1'b1;
                        w_state_nxt = DetIdle;
                    end
                end
                default: w_state_nxt = DetIdle;
            endcase
        end
    end

endmodule

// File: rtl/seq_frame_ctrl.sv
// Frame controller: loads bytes, shifts them out MSB first and counts "110" detections per frame.
module seq_frame_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    output logic             o_in_ready,
    output logic             o_busy,
    output logic             o_det_pulse,
    output logic [CNT_W-1:0] o_det_count,
    output logic             o_done
);

    localparam int unsigned BitCntW = $clog2(BitsPerByte);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(BitsPerByte - 1);
    localparam logic [7:0] FrameBytes = 8'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    frame_state_e r_state;
    frame_state_e w_state_nxt;

    logic [BitsPerByte-1:0] r_shift;
    logic [BitCntW-1:0]     r_bit_cnt;
    logic [7:0]             r_byte_cnt;
    logic [CNT_W-1:0]       r_det_count;
    logic                   r_det_pulse;

    logic w_accept;
    logic w_abort;
    logic w_take;
    logic w_shift_en;
    logic w_last_bit;
    logic w_det_clr;
    logic w_hit;

    assign w_accept   = (r_state == StIdle) & i_start & ~i_abort;
    assign w_abort    = (r_state != StIdle) & i_abort;
    assign w_take     = (r_state == StLoad) & i_in_valid & ~i_abort;
    assign w_shift_en = (r_state == StShift) & ~i_abort;
    assign w_last_bit = (r_bit_cnt == LastBit);
    assign w_det_clr  = w_accept | w_abort;

    assign o_det_pulse = r_det_pulse;
    assign o_det_count = r_det_count;

    seq_bit_det u_bit_det (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_det_clr),
        .i_bit_en (w_shift_en),
        .i_bit_in (r_shift[BitsPerByte-1]),
        .o_hit    (w_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                o_in_ready = 1'b1;
                if (i_abort) begin
                    w_state_nxt = StIdle;
                end else if (i_in_valid) begin
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                if (i_abort) begin
                    w_state_nxt = StIdle;
                end else if (w_last_bit) begin
                    w_state_nxt = (r_byte_cnt < FrameBytes) ? StLoad : StDone;
                end
            end
            StDone: begin
                // An abort landing on the completion cycle suppresses the done strobe.
                o_done      = ~i_abort;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_det_count <= '0;
            r_det_pulse <= 1'b0;
        end else begin
            r_det_pulse <= w_hit;
            if (w_accept) begin
                r_byte_cnt  <= '0;
                r_bit_cnt   <= '0;
                r_det_count <= '0;
            end else if (w_abort) begin
                r_bit_cnt   <= '0;
                r_det_count <= '0;
            end else begin
                if (w_take) begin
                    r_shift    <= i_in_data;
                    r_byte_cnt <= r_byte_cnt + 8'd1;
                    r_bit_cnt  <= '0;
                end
                if (w_shift_en) begin
                    r_shift   <= {r_shift[BitsPerByte-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + BitCntW'(1);
                end
                if (w_hit && (r_det_count != CntMax)) begin
                    r_det_count <= r_det_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Scoreboard bench for seq_frame_ctrl: two instances (1-byte frames, and 4-byte frames with a 2-bit counter).
module tb_seq_frame_ctrl;

    localparam int unsigned FB0 = 1;
    localparam int unsigned CW0 = 6;
    localparam int unsigned FB1 = 4;
    localparam int unsigned CW1 = 2;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int count;
        int pulses;
        int done_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       st[2];
    logic       ab[2];
    logic       iv[2];
    logic [7:0] id[2];
    logic       rdy[2];
    logic       bsy[2];
    logic       dp[2];
    logic       dn[2];
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   pend[2];
    exp_t q0[$];
    exp_t q1[$];

    seq_frame_ctrl #(.FRAME_BYTES(FB0), .CNT_W(CW0)) u_dut0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (st[0]),
        .i_abort     (ab[0]),
        .i_in_valid  (iv[0]),
        .i_in_data   (id[0]),
        .o_in_ready  (rdy[0]),
        .o_busy      (bsy[0]),
        .o_det_pulse (dp[0]),
        .o_det_count (cnt0),
        .o_done      (dn[0])
    );

    seq_frame_ctrl #(.FRAME_BYTES(FB1), .CNT_W(CW1)) u_dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (st[1]),
        .i_abort     (ab[1]),
        .i_in_valid  (iv[1]),
        .i_in_data   (id[1]),
        .o_in_ready  (rdy[1]),
        .o_busy      (bsy[1]),
        .o_det_pulse (dp[1]),
        .o_det_count (cnt1),
        .o_done      (dn[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic int cnt_of(input int k);
        return (k == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // Reference: scan the frame's bit string for non-overlapping "110" windows.
    function automatic exp_t model(input byte_q_t b, input int maxc);
        bit   bits[$];
        logic [7:0] v;
        int   i;
        int   hits;
        exp_t e;
        foreach (b[n]) begin
            v = b[n];
            for (int j = 7; j >= 0; j--) bits.push_back(v[j]);
        end
        i    = 0;
        hits = 0;
        while (i + 2 < bits.size()) begin
            if (bits[i] && bits[i+1] && !bits[i+2]) begin
                hits++;
                i += 3;
            end else begin
                i++;
            end
        end
        e.count    = (hits > maxc) ? maxc : hits;
        e.pulses   = hits;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pulses are tallied per frame and compared, with the final count, on each done.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || ab[k]) begin
                pend[k] = 0;
            end else begin
                if (dp[k]) pend[k]++;
                if (dn[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_done inst%0d: got done=1, expected 0", k);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check($sformatf("det_count_at_done%0d", k), cnt_of(k), e.count);
                        check($sformatf("pulse_count%0d", k), pend[k], e.pulses);
                        check($sformatf("done_cycle%0d", k), cyc, e.done_cyc);
                    end
                    pend[k] = 0;
                end
            end
        end
    end

    task automatic send_frame(input int k, input byte_q_t b, input int ab_byte, input int ab_cyc);
        int   hs;
        int   gap;
        int   tries;
        bit   got;
        exp_t e;
        tries = 0;
        while (bsy[k] && tries < 50) begin
            tick();
            tries++;
        end
        if (bsy[k]) begin
            bound_fail("idle_wait");
            return;
        end
        st[k] = 1'b1;
        tick();
        for (int n = 0; n < b.size(); n++) begin
            gap = $urandom_range(0, 2);
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                st[k] = 1'($urandom);
                if (rdy[k] && gap == 0) begin
                    iv[k] = 1'b1;
                    id[k] = b[n];
                    hs    = cyc;
                    got   = 1'b1;
                    if (n == b.size() - 1 && ab_byte < 0) begin
                        e          = model(b, (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1));
                        e.done_cyc = hs + 9;
                        if (k == 0) q0.push_back(e);
                        else q1.push_back(e);
                    end
                end else if (rdy[k]) begin
                    iv[k] = 1'b0;
                    gap--;
                end else begin
                    iv[k] = 1'($urandom);
                    id[k] = 8'($urandom);
                end
                tick();
            end
            if (!got) begin
                bound_fail("byte_handshake");
                st[k] = 1'b0;
                iv[k] = 1'b0;
                return;
            end
            if (n == ab_byte) begin
                iv[k] = 1'b0;
                st[k] = 1'b0;
                repeat (ab_cyc - 1) tick();
                ab[k] = 1'b1;
                tick();
                ab[k] = 1'b0;
                check("abort_busy", int'(bsy[k]), 0);
                check("abort_count", cnt_of(k), 0);
                check("abort_ready", int'(rdy[k]), 0);
                check("abort_done", int'(dn[k]), 0);
                return;
            end
        end
        iv[k] = 1'b0;
        st[k] = 1'b0;
        tries = 0;
        while (!dn[k] && tries < 40) begin
            tick();
            tries++;
        end
        if (!dn[k]) begin
            bound_fail("done_wait");
            return;
        end
        tick();
        check("busy_after_done", int'(bsy[k]), 0);
        check("ready_after_done", int'(rdy[k]), 0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ready%0d", tag, k), int'(rdy[k]), 0);
            check($sformatf("%s_busy%0d", tag, k), int'(bsy[k]), 0);
            check($sformatf("%s_pulse%0d", tag, k), int'(dp[k]), 0);
            check($sformatf("%s_done%0d", tag, k), int'(dn[k]), 0);
            check($sformatf("%s_count%0d", tag, k), cnt_of(k), 0);
        end
    endtask

    initial begin
        byte_q_t b;
        int      k;
        int      nb;
        int      abb;
        int      abc;
        int      tries;
        for (int i = 0; i < 2; i++) begin
            st[i]   = 1'b0;
            ab[i]   = 1'b0;
            iv[i]   = 1'b0;
            id[i]   = 8'h00;
            pend[i] = 0;
        end
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_reset", int'(bsy[0]) + int'(bsy[1]), 0);

        b = '{8'hD8};                      send_frame(0, b, -1, 0);
        b = '{8'h6D};                      send_frame(0, b, -1, 0);
        b = '{8'hFF, 8'h00, 8'h00, 8'h00}; send_frame(1, b, -1, 0);
        b = '{8'hDB, 8'hDB, 8'hDB, 8'hDB}; send_frame(1, b, -1, 0);
        b = '{8'hDB, 8'hDB, 8'hDB, 8'hDB}; send_frame(1, b, 0, 4);
        b = '{8'hD8, 8'h6D, 8'h0E, 8'h07}; send_frame(1, b, -1, 0);
        b = '{8'hD8};                      send_frame(0, b, 0, 4);
        b = '{8'hEE};                      send_frame(0, b, -1, 0);

        // Reset in the middle of shifting a byte.
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        tries = 0;
        while (!rdy[1] && tries < 10) begin
            tick();
            tries++;
        end
        iv[1] = 1'b1;
        id[1] = 8'hDB;
        tick();
        iv[1] = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_midreset", int'(bsy[1]), 0);

        // Start and abort together in IDLE: abort wins.
        st[1] = 1'b1;
        ab[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        ab[1] = 1'b0;
        check("start_abort_busy", int'(bsy[1]), 0);
        check("start_abort_ready", int'(rdy[1]), 0);
        tick();
        check("start_abort_busy2", int'(bsy[1]), 0);

        for (int r = 0; r < 24; r++) begin
            k  = r % 2;
            nb = (k == 0) ? FB0 : FB1;
            b  = {};
            for (int n = 0; n < nb; n++) b.push_back(8'($urandom));
            abb = -1;
            abc = 0;
            if ($urandom_range(0, 5) == 0) begin
                abb = $urandom_range(0, nb - 1);
                abc = $urandom_range(1, 8);
            end
            send_frame(k, b, abb, abc);
        end

        repeat (20) tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_frame_ctrl.md
SEQ_FRAME_CTRL -- requirements
Module: seq_frame_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter FRAME_BYTES, default 4: number of bytes per frame (1..255).
REQ-003 Parameter CNT_W, default 6: width of the detection counter.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous reset, active low.
REQ-006 start  input  1  frame start request, sampled in IDLE only.
REQ-007 abort  input  1  cancels the current frame.
REQ-008 in_valid  input  1  byte available on in_data.
REQ-009 in_data  input  8  byte, serialized MSB first.
REQ-010 in_ready  output  1  block accepts a byte this cycle.
REQ-011 busy  output  1  frame in progress (any state other than IDLE).
REQ-012 det_pulse  output  1  registered strobe, one cycle per "110" detection.
REQ-013 det_count  output  CNT_W  detections in the current or last frame.
REQ-014 done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 The control FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-016 IDLE: start=1 and abort=0 -> LOAD; on that transition, clear det_count, the bit-detector state and the byte counter.
REQ-017 LOAD: in_ready=1; on in_valid&in_ready, capture in_data into the shift register -> SHIFT.
REQ-018 SHIFT: present one bit per cycle, MSB first, for exactly 8 cycles.
REQ-019 After the 8th bit: if bytes accepted < FRAME_BYTES -> LOAD, else -> DONE.
REQ-020 DONE: done=1 for one cycle -> IDLE; det_count holds its value until the next accepted start.
REQ-021 in_ready SHALL be 1 only in LOAD and SHALL be combinational from state only, never from in_valid.
REQ-022 The embedded detector SHALL be a Mealy "110" recognizer with states D_IDLE, D_S1 and D_S11, advancing only on SHIFT cycles.
REQ-023 D_IDLE: bit 1 -> D_S1; bit 0 -> D_IDLE.
REQ-024 D_S1: bit 1 -> D_S11; bit 0 -> D_IDLE.
REQ-025 D_S11: bit 1 -> D_S11; bit 0 -> detection, then D_IDLE.
REQ-026 Patterns SHALL NOT overlap, and detector state SHALL persist across byte boundaries within a frame.
REQ-027 On each detection: det_pulse=1 on the following cycle (latency 1 from the bit's SHIFT cycle), and det_count increments.
REQ-028 det_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 abort=1 in LOAD, SHIFT or DONE -> IDLE on the next edge; no done pulse; det_count cleared; detector to D_IDLE.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 start=1 and abort=1 together in IDLE: abort wins, FSM stays in IDLE.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 in_valid outside LOAD SHALL be ignored, and no byte is consumed.
REQ-034 A detection on the final bit SHALL be counted, with det_count final in the same cycle that done=1.

Reset
REQ-035 reset=0 SHALL immediately force: FSM=IDLE, detector=D_IDLE, in_ready=0, busy=0, done=0, det_pulse=0, det_count=0, shift register=0, byte counter=0.
REQ-036 Reset asserted mid-frame SHALL discard the frame with no done pulse.
REQ-037 After reset deassertion, the block SHALL take no action until start is accepted.

Structure
REQ-038 The FSM state encodings (IDLE/LOAD/SHIFT/DONE, D_IDLE/D_S1/D_S11) and the bits-per-byte constant (8) SHALL live in the shared package seq_pkg.
REQ-039 The bit detector SHALL be a sub-module, seq_bit_det, with inputs Clock, reset, bit_en and bit_in, and output hit.
REQ-040 The byte counter, shift register, bit counter and det_count SHALL reside in seq_frame_ctrl.

Verification
REQ-041 FRAME_BYTES=1, byte 0xD8 (11011000) -> det_count=2; two det_pulse strobes; done exactly 9 cycles after the handshake cycle.
REQ-042 FRAME_BYTES=2, bytes 0xFF then 0x00 -> one detection on the first bit of byte 2 (cross-byte); det_count=1.
REQ-043 FRAME_BYTES=1, byte 0x6D (01101101) -> det_count=2; FSM returns to IDLE with busy=0 the cycle after done.
REQ-044 CNT_W=2, FRAME_BYTES=4, four bytes 0xDB (11011011) -> det_count saturates at 3, no wrap.
REQ-045 abort asserted on the 4th SHIFT cycle -> IDLE next cycle; no done; det_count=0; a subsequent frame counts correctly.
REQ-046 reset pulled low mid-SHIFT, and start+abort together in IDLE -> all outputs 0 immediately; FSM remains IDLE.
